// File: rtl/mult_share_ctrl.sv
// mult_share_ctrl
// Round-robin sequencer that shares one signed sequential multiplier engine
// among N requesters. The winner's operands are latched at grant time, the
// engine is driven with its level-start/ready protocol, and the 2W-bit
// product is returned with a one-cycle done pulse. A watchdog aborts any run
// whose engine ready never shows up.
//
// Handshake: a requester raises req[i] with stable operands and holds it until
// done[i] pulses; gnt[i] marks ownership from LOAD through DONE/ABORT. On the
// engine side mul_start is a level: low loads operands, high runs, and
// mul_ready is only trusted while mul_start is high and the FSM is in RUN.
module mult_share_ctrl #(
    parameter int N       = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N-1:0]     req,
    input  logic [N*W-1:0]   a_in,
    input  logic [N*W-1:0]   b_in,
    output logic [N-1:0]     gnt,
    output logic [N-1:0]     done,
    output logic [2*W-1:0]   result,
    output logic             err,
    output logic             busy,
    output logic             mul_start,
    output logic [W-1:0]     mul_a,
    output logic [W-1:0]     mul_b,
    input  logic             mul_ready,
    input  logic [2*W-1:0]   mul_product,
    output logic [2:0]       dbg_state
);

    localparam int IW  = (N > 1) ? $clog2(N) : 1;
    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DONE  = 3'd3,
        S_ABORT = 3'd4
    } state_t;

    // Registered state and outputs
    state_t           r_state;
    logic [N-1:0]     r_gnt;
    logic [N-1:0]     r_done;
    logic [2*W-1:0]   r_result;
    logic             r_err;
    logic             r_mul_start;
    logic [W-1:0]     r_mul_a;
    logic [W-1:0]     r_mul_b;
    logic [IW-1:0]    r_rr_ptr;
    logic [IW-1:0]    r_gidx;
    logic [WDW-1:0]   r_wd_cnt;

    // Next-state values
    state_t           w_state_nxt;
    logic [N-1:0]     w_gnt_nxt;
    logic [N-1:0]     w_done_nxt;
    logic [2*W-1:0]   w_result_nxt;
    logic             w_err_nxt;
    logic             w_mul_start_nxt;
    logic [W-1:0]     w_mul_a_nxt;
    logic [W-1:0]     w_mul_b_nxt;
    logic [IW-1:0]    w_rr_ptr_nxt;
    logic [IW-1:0]    w_gidx_nxt;
    logic [WDW-1:0]   w_wd_cnt_nxt;

    // Arbitration result
    logic             w_found;
    logic [IW-1:0]    w_pick;
    logic [W-1:0]     w_pick_a;
    logic [W-1:0]     w_pick_b;
    logic [IW-1:0]    w_next_ptr;

    // Index arithmetic modulo N without relying on N being a power of two.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Round-robin pick: first asserted request scanning upward from rr_ptr with wrap
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && req[wrap_add(r_rr_ptr, k)]) begin
                w_found = 1'b1;
                w_pick  = wrap_add(r_rr_ptr, k);
            end
        end
    end

    assign w_pick_a   = a_in[int'(w_pick)*W +: W];
    assign w_pick_b   = b_in[int'(w_pick)*W +: W];
    assign w_next_ptr = wrap_add(r_gidx, 1);

    // Next-state and registered-output logic; every value holds unless a state changes it
    always_comb begin
        w_state_nxt     = r_state;
        w_gnt_nxt       = r_gnt;
        w_done_nxt      = '0;
        w_result_nxt    = r_result;
        w_err_nxt       = 1'b0;
        w_mul_start_nxt = r_mul_start;
        w_mul_a_nxt     = r_mul_a;
        w_mul_b_nxt     = r_mul_b;
        w_rr_ptr_nxt    = r_rr_ptr;
        w_gidx_nxt      = r_gidx;
        w_wd_cnt_nxt    = r_wd_cnt;

        case (r_state)
            S_IDLE: begin
                w_mul_start_nxt = 1'b0;
                w_wd_cnt_nxt    = '0;
                if (w_found) begin
                    w_gnt_nxt   = {{(N-1){1'b0}}, 1'b1} << w_pick;
                    w_gidx_nxt  = w_pick;
                    w_mul_a_nxt = w_pick_a;
                    w_mul_b_nxt = w_pick_b;
                    w_state_nxt = S_LOAD;
                end
            end

            // One cycle with start low lets the engine sample the latched operands.
            S_LOAD: begin
                w_mul_start_nxt = 1'b1;
                w_wd_cnt_nxt    = '0;
                w_state_nxt     = S_RUN;
            end

            S_RUN: begin
                w_wd_cnt_nxt = r_wd_cnt + 1'b1;
                if (mul_ready) begin
                    w_result_nxt    = mul_product;
                    w_mul_start_nxt = 1'b0;
                    w_done_nxt      = r_gnt;
                    w_rr_ptr_nxt    = w_next_ptr;
                    w_state_nxt     = S_DONE;
                end else if (r_wd_cnt == WDW'(TIMEOUT - 1)) begin
                    w_mul_start_nxt = 1'b0;
                    w_done_nxt      = r_gnt;
                    w_err_nxt       = 1'b1;
                    w_rr_ptr_nxt    = w_next_ptr;
                    w_state_nxt     = S_ABORT;
                end
            end

            // done/err are high during these states; the grant is released on exit.
            S_DONE, S_ABORT: begin
                w_mul_start_nxt = 1'b0;
                w_gnt_nxt       = '0;
                w_wd_cnt_nxt    = '0;
                w_state_nxt     = S_IDLE;
            end

            default: begin
                w_mul_start_nxt = 1'b0;
                w_gnt_nxt       = '0;
                w_wd_cnt_nxt    = '0;
                w_state_nxt     = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset clears everything, including the rr pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_gnt       <= '0;
            r_done      <= '0;
            r_result    <= '0;
            r_err       <= 1'b0;
            r_mul_start <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
            r_rr_ptr    <= '0;
            r_gidx      <= '0;
            r_wd_cnt    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_gnt       <= w_gnt_nxt;
            r_done      <= w_done_nxt;
            r_result    <= w_result_nxt;
            r_err       <= w_err_nxt;
            r_mul_start <= w_mul_start_nxt;
            r_mul_a     <= w_mul_a_nxt;
            r_mul_b     <= w_mul_b_nxt;
            r_rr_ptr    <= w_rr_ptr_nxt;
            r_gidx      <= w_gidx_nxt;
            r_wd_cnt    <= w_wd_cnt_nxt;
        end
    end

    assign gnt       = r_gnt;
    assign done      = r_done;
    assign result    = r_result;
    assign err       = r_err;
    assign busy      = (r_state != S_IDLE);
    assign mul_start = r_mul_start;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_mult_share_ctrl.sv
// Directed bench for mult_share_ctrl with a behavioural 8-bit engine model.
// Engine: loads operands while start is low; after 16 edges with start high it
// raises a sticky ready with the product, so start stays high L=17 cycles
// before the controller samples ready. Counting from the cycle a request is
// presented to an idle controller, done is visible after tick 19 (grant edge,
// LOAD edge, 17 RUN cycles); a watchdog abort is visible after tick 34.
module tb_mult_share_ctrl;
  localparam int N = 4;
  localparam int W = 8;
  localparam int TIMEOUT = 32;
  localparam int LAT_OK = 19;
  localparam int LAT_ABORT = TIMEOUT + 2;

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [N-1:0]   req;
  logic [N*W-1:0] a_in;
  logic [N*W-1:0] b_in;
  logic [N-1:0]   gnt;
  logic [N-1:0]   done;
  logic [2*W-1:0] result;
  logic           err;
  logic           busy;
  logic           mul_start;
  logic [W-1:0]   mul_a;
  logic [W-1:0]   mul_b;
  logic           mul_ready;
  logic [2*W-1:0] mul_product;
  logic [2:0]     dbg_state;

  mult_share_ctrl #(.N(N), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .done(done), .result(result), .err(err), .busy(busy),
    .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_ready(mul_ready), .mul_product(mul_product), .dbg_state(dbg_state)
  );

  // engine model
  logic [W-1:0]   e_a, e_b;
  logic [4:0]     e_cnt;
  logic           e_ready;
  logic [2*W-1:0] e_prod;
  logic           stall;
  logic           stale;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      e_a <= '0; e_b <= '0; e_cnt <= '0; e_ready <= 1'b0; e_prod <= '0;
    end else if (!mul_start) begin
      e_a <= mul_a; e_b <= mul_b; e_cnt <= '0; e_ready <= 1'b0;
    end else if (!e_ready) begin
      e_cnt <= e_cnt + 5'd1;
      if (e_cnt == 5'd15) begin
        e_ready <= 1'b1;
        e_prod  <= {{W{e_a[W-1]}}, e_a} * {{W{e_b[W-1]}}, e_b};
      end
    end
  end

  assign mul_ready   = !stall && (e_ready || stale);
  assign mul_product = e_prod;

  // scoreboard counters
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  // Wait (bounded) for done, check the completion, then release req unless keep.
  task automatic serve(input string tag, input int idx, input logic [15:0] exp_res,
                       input logic exp_err, input int exp_ticks, input bit keep);
    int t;
    bit bad;
    logic [N-1:0] own;
    own = 4'b0001 << idx;
    t = 0;
    bad = 1'b0;
    while (done == '0 && t < 100) begin
      tick();
      t++;
      if (gnt != '0 && gnt != own) bad = 1'b1;
    end
    check({tag, "_latency"}, t, exp_ticks);
    check({tag, "_done"}, done, own);
    check({tag, "_gnt"}, gnt, own);
    check({tag, "_result"}, result, exp_res);
    check({tag, "_err"}, err, exp_err);
    check({tag, "_gnt_onehot"}, bad, 0);
    if (!keep) req[idx] = 1'b0;
    tick();
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_gnt_release"}, gnt, 0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_gnt"}, gnt, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mul_start"}, mul_start, 0);
    check({tag, "_mul_a"}, mul_a, 0);
    check({tag, "_mul_b"}, mul_b, 0);
    check({tag, "_state"}, dbg_state, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    reset = 1'b1; req = '0; a_in = '0; b_in = '0; stall = 1'b0; stale = 1'b0;
    tick(); tick();
    check_all_zero("reset");
    reset = 1'b0;
    tick();

    // 1: single request 3 * -5, stale ready during LOAD must be ignored
    set_op(0, 8'd3, 8'hFB);
    req[0] = 1'b1;
    tick();
    check("t1_gnt", gnt, 4'b0001);
    check("t1_busy", busy, 1);
    check("t1_state_load", dbg_state, 1);
    check("t1_mul_a", mul_a, 8'd3);
    check("t1_mul_b", mul_b, 8'hFB);
    check("t1_start_low", mul_start, 0);
    stale = 1'b1;
    tick();
    stale = 1'b0;
    check("t1_state_run", dbg_state, 2);
    check("t1_start_high", mul_start, 1);
    check("t1_no_early_done", done, 0);
    serve("t1", 0, 16'hFFF1, 1'b0, LAT_OK - 2, 1'b0);

    // 2: all four requesting after reset -> order 0,1,2,3
    reset = 1'b1; #1; reset = 1'b0;
    tick();
    set_op(0, 8'd2, 8'd3);
    set_op(1, 8'hF9, 8'd9);
    set_op(2, 8'd100, 8'hFE);
    set_op(3, 8'hF4, 8'hF5);
    req = 4'b1111;
    serve("t2_r0", 0, 16'h0006, 1'b0, LAT_OK, 1'b0);
    serve("t2_r1", 1, 16'hFFC1, 1'b0, LAT_OK, 1'b0);
    serve("t2_r2", 2, 16'hFF38, 1'b0, LAT_OK, 1'b0);
    serve("t2_r3", 3, 16'h0084, 1'b0, LAT_OK, 1'b0);

    // 3: req0 kept high after its done while req2 pends -> 0, 2, 0
    set_op(0, 8'd5, 8'hFA);
    set_op(2, 8'hFF, 8'hFF);
    req = 4'b0101;
    serve("t3_r0", 0, 16'hFFE2, 1'b0, LAT_OK, 1'b1);
    serve("t3_r2", 2, 16'h0001, 1'b0, LAT_OK, 1'b0);
    serve("t3_r0b", 0, 16'hFFE2, 1'b0, LAT_OK, 1'b0);

    // 4: extremes; operands changed after grant must not matter
    set_op(1, 8'h80, 8'h80);
    req[1] = 1'b1;
    tick();
    check("t4_latch_a", mul_a, 8'h80);
    set_op(1, 8'd0, 8'd0);
    serve("t4_r1", 1, 16'h4000, 1'b0, LAT_OK - 1, 1'b0);
    set_op(2, 8'h7F, 8'h80);
    req[2] = 1'b1;
    serve("t4_r2", 2, 16'hC080, 1'b0, LAT_OK, 1'b0);

    // 5: engine never ready -> abort with err, result unchanged
    stall = 1'b1;
    set_op(3, 8'd4, 8'd4);
    req[3] = 1'b1;
    serve("t5_abort", 3, 16'hC080, 1'b1, LAT_ABORT, 1'b0);
    stall = 1'b0;
    check("t5_err_pulse", err, 0);

    // 6: reset 5 cycles into RUN, then normal service resumes from rr_ptr=0
    set_op(1, 8'hFD, 8'd5);
    req[1] = 1'b1;
    tick(); tick();
    for (int i = 0; i < 5; i++) tick();
    check("t6_in_run", dbg_state, 2);
    check("t6_gnt_before", gnt, 4'b0010);
    reset = 1'b1;
    #1;
    check_all_zero("t6_reset");
    tick();
    check("t6_no_done", done, 0);
    reset = 1'b0;
    set_op(0, 8'd6, 8'd7);
    req = 4'b0011;
    serve("t6_r0", 0, 16'h002A, 1'b0, LAT_OK, 1'b0);
    serve("t6_r1", 1, 16'hFFF1, 1'b0, LAT_OK, 1'b0);

    // final report
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
